multicycle_ctrl_seq: RTL and testbench

Parametrised successor to the fixed-sequence instruction controller for the multi-cycle core. It fetches each instruction from IM with a req/ready handshake and latches it. It then decodes the 32-bit ISA and walks only the states each instruction class needs, with a req/ready handshake to DM for loads and stores. It also retires instructions, counts them, and raises done after total_ir instructions. It sits between the IM/DM wrappers and the regfile/ALU/immediate-mux datapath.

---
 rtl/multicycle_ctrl_seq.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_seq.sv
// multicycle_ctrl_seq: fetch/decode/execute controller for the multi-cycle core (optional stall counter: PERF_STALL_CNT_EN)
module multicycle_ctrl_seq #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5,
  parameter int PcSize   = 10,
  parameter int CntSize  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [PcSize-1:0]   total_ir,
  input  logic [DataSize-1:0] ir,
  input  logic                im_ready,
  input  logic                dm_ready,
  output logic [PcSize-1:0]   pc,
  output logic                im_req,
  output logic                dm_req,
  output logic                dm_we,
  output logic                reg_read_en,
  output logic                alu_en,
  output logic                reg_write_en,
  output logic                wb_sel,
  output logic [1:0]          imm_sel,
  output logic                alu_src2_sel,
  output logic [5:0]          opcode,
  output logic [AddrSize-1:0] write_address,
  output logic [AddrSize-1:0] read_address1,
  output logic [AddrSize-1:0] read_address2,
  output logic [CntSize-1:0]  ins_cnt,
  output logic [CntSize-1:0]  stall_cnt,
  output logic                done,
  output logic                illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, RETIRE, DONE} state_t;
  state_t              state_q, state_d;
  logic [PcSize-1:0]   pc_q, pc_d;
  logic [DataSize-1:0] ir_q, ir_d;
  logic [CntSize-1:0]  ins_cnt_q, ins_cnt_d;
  logic                illegal_q, illegal_d;
  logic [PcSize:0]     pc_nxt;
  logic [4:0]          sub5, imm5;
  logic [7:0]          sub8;
  logic is_alu_r, is_shift, is_addi, is_ori, is_xori, is_movi, is_lwi, is_swi, is_lw, is_sw;
  logic is_nop, is_ld, is_st, legal, launch;
  assign opcode        = ir_q[30:25];
  assign write_address = ir_q[24:20];
  assign read_address1 = ir_q[19:15];
  assign read_address2 = ir_q[14:10];
  assign imm5          = ir_q[9:5];
  assign sub5          = ir_q[4:0];
  assign sub8          = ir_q[7:0];
  assign is_alu_r = opcode == 6'b100000 && (sub5 inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                    5'b00100, 5'b01000, 5'b01001, 5'b01011});
  assign is_shift = opcode == 6'b100000 && (sub5 inside {5'b01000, 5'b01001, 5'b01011});
  assign is_nop   = opcode == 6'b100000 && sub5 == 5'b01001 && imm5 == 5'd0;
  assign is_addi  = opcode == 6'b101000;
  assign is_ori   = opcode == 6'b101100;
  assign is_xori  = opcode == 6'b101011;
  assign is_movi  = opcode == 6'b100010;
  assign is_lwi   = opcode == 6'b000010;
  assign is_swi   = opcode == 6'b001010;
  assign is_lw    = opcode == 6'b011100 && sub8 == 8'b00000010;
  assign is_sw    = opcode == 6'b011100 && sub8 == 8'b00001010;
  assign is_ld    = is_lwi | is_lw;
  assign is_st    = is_swi | is_sw;
  assign legal    = is_alu_r | is_addi | is_ori | is_xori | is_movi | is_ld | is_st;
  assign imm_sel      = is_addi ? 2'd1 : (is_ori | is_xori | is_lwi | is_swi) ? 2'd2 : is_movi ? 2'd3 : 2'd0;
  assign alu_src2_sel = is_shift | is_addi | is_ori | is_xori | is_movi | is_lwi | is_swi;
  assign wb_sel       = is_ld;
  assign im_req       = state_q == FETCH;
  assign reg_read_en  = state_q == DECODE;
  assign alu_en       = state_q == EXEC;
  assign dm_req       = state_q == MEM;
  assign dm_we        = dm_req & is_st;
  assign reg_write_en = state_q == WB;
  assign done         = state_q == DONE;
  assign pc           = pc_q;
  assign ins_cnt      = ins_cnt_q;
  assign illegal      = illegal_q;
  assign launch       = start && (state_q == IDLE || state_q == DONE);
  assign pc_nxt       = {1'b0, pc_q} + {{PcSize{1'b0}}, 1'b1};
  // next-state and datapath register updates per controller state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ins_cnt_d = ins_cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        pc_d      = '0;
        ins_cnt_d = '0;
        illegal_d = 1'b0;
        state_d   = total_ir == '0 ? DONE : FETCH;
      end
      FETCH: if (im_ready) begin
        ir_d    = ir;
        state_d = DECODE;
      end
      DECODE: begin
        illegal_d = illegal_q | ~legal;
        state_d   = (!legal || is_nop) ? RETIRE : EXEC;
      end
      EXEC:   state_d = (is_ld || is_st) ? MEM : WB;
      MEM:    if (dm_ready) state_d = is_ld ? WB : RETIRE;
      WB:     state_d = RETIRE;
      RETIRE: begin
        pc_d      = pc_nxt[PcSize-1:0];
        ins_cnt_d = ins_cnt_q + {{(CntSize-1){1'b0}}, ~&ins_cnt_q};
        state_d   = pc_nxt >= {1'b0, total_ir} ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      ins_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ins_cnt_q <= ins_cnt_d;
      illegal_q <= illegal_d;
    end
  end
`ifdef PERF_STALL_CNT_EN
  logic [CntSize-1:0] stall_cnt_q, stall_cnt_d;
  logic               stalled;
  assign stalled   = (im_req & ~im_ready) | (dm_req & ~dm_ready);
  assign stall_cnt = stall_cnt_q;
  // saturating count of handshake wait cycles, cleared when a run launches
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (launch) stall_cnt_d = '0;
    else if (stalled && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + {{(CntSize-1){1'b0}}, 1'b1};
  end
  // stall counter register
  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
`else
  logic unused_launch;
  assign unused_launch = launch;
  assign stall_cnt     = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// tb_multicycle_ctrl_seq: directed self-checking bench for multicycle_ctrl_seq
module tb_multicycle_ctrl_seq;
  logic        clock = 1'b0;
  logic        reset, start, im_ready, dm_ready;
  logic [9:0]  total_ir, pc, write_address_w, read_address1_w, read_address2_w;
  logic [31:0] ir;
  logic        im_req, dm_req, dm_we, reg_read_en, alu_en, reg_write_en, wb_sel, alu_src2_sel, done, illegal;
  logic [1:0]  imm_sel;
  logic [5:0]  opcode;
  logic [4:0]  write_address, read_address1, read_address2;
  logic [63:0] ins_cnt, stall_cnt;
  logic [31:0] prog [1024];
  int          err_cnt = 0, chk_cnt = 0, n;
`ifdef PERF_STALL_CNT_EN
  localparam bit StallOn = 1'b1;
`else
  localparam bit StallOn = 1'b0;
`endif
  localparam logic [31:0] ADDI = {1'b0, 6'b101000, 5'd1, 5'd2, 15'd5};
  localparam logic [31:0] ADD  = {1'b0, 6'b100000, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00000};
  localparam logic [31:0] NOP  = {1'b0, 6'b100000, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01001};
  localparam logic [31:0] LWI  = {1'b0, 6'b000010, 5'd4, 5'd0, 15'd8};
  localparam logic [31:0] SWI  = {1'b0, 6'b001010, 5'd4, 5'd0, 15'd8};
  localparam logic [31:0] ILL  = {1'b0, 6'b111111, 25'd0};
  assign ir = im_ready ? prog[pc] : 32'hFFFF_FFFF;
  always #5 clock = ~clock;
  multicycle_ctrl_seq dut (
    .clock(clock), .reset(reset), .start(start), .total_ir(total_ir), .ir(ir),
    .im_ready(im_ready), .dm_ready(dm_ready), .pc(pc), .im_req(im_req), .dm_req(dm_req),
    .dm_we(dm_we), .reg_read_en(reg_read_en), .alu_en(alu_en), .reg_write_en(reg_write_en),
    .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_src2_sel(alu_src2_sel), .opcode(opcode),
    .write_address(write_address), .read_address1(read_address1), .read_address2(read_address2),
    .ins_cnt(ins_cnt), .stall_cnt(stall_cnt), .done(done), .illegal(illegal)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic run_to_done(input int n0, input int lim, output int cyc);
    cyc = n0;
    while (!done && cyc < lim) begin
      tick();
      cyc++;
    end
    if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    foreach (prog[i]) prog[i] = NOP;
    reset = 1'b1; start = 1'b0; im_ready = 1'b1; dm_ready = 1'b1; total_ir = 10'd0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pc", {54'd0, pc}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_ins_cnt", ins_cnt, 64'd0);
    chk("rst_stall", stall_cnt, 64'd0);
    chk("rst_strobes", {58'd0, im_req, dm_req, reg_read_en, alu_en, reg_write_en, dm_we}, 64'd0);
    // ADDI, ADD, NOP with zero-wait memories
    prog[0] = ADDI; prog[1] = ADD; prog[2] = NOP; total_ir = 10'd3;
    pulse_start();
    chk("t1_fetch_im_req", {63'd0, im_req}, 64'd1);
    chk("t1_fetch_pc", {54'd0, pc}, 64'd0);
    tick();
    chk("t1_dec_rd_en", {63'd0, reg_read_en}, 64'd1);
    chk("t1_addi_opcode", {58'd0, opcode}, 64'b101000);
    chk("t1_addi_wa", {59'd0, write_address}, 64'd1);
    chk("t1_addi_ra1", {59'd0, read_address1}, 64'd2);
    chk("t1_addi_imm_sel", {62'd0, imm_sel}, 64'd1);
    chk("t1_addi_src2", {63'd0, alu_src2_sel}, 64'd1);
    tick();
    chk("t1_exec_alu_en", {63'd0, alu_en}, 64'd1);
    run_to_done(2, 100, n);
    chk("t1_cycles", n, 64'd13);
    chk("t1_ins_cnt", ins_cnt, 64'd3);
    chk("t1_pc", {54'd0, pc}, 64'd3);
    chk("t1_illegal", {63'd0, illegal}, 64'd0);
    // LWI then SWI with four DM wait cycles each
    prog[0] = LWI; prog[1] = SWI; total_ir = 10'd2; dm_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    chk("t2_lwi_dm_req", {63'd0, dm_req}, 64'd1);
    chk("t2_lwi_dm_we", {63'd0, dm_we}, 64'd0);
    chk("t2_lwi_wb_sel", {63'd0, wb_sel}, 64'd1);
    chk("t2_lwi_imm_sel", {62'd0, imm_sel}, 64'd2);
    repeat (4) tick();
    chk("t2_lwi_dm_held", {63'd0, dm_req}, 64'd1);
    dm_ready = 1'b1;
    tick();
    dm_ready = 1'b0;
    chk("t2_lwi_wb", {62'd0, reg_write_en, dm_req}, 64'b10);
    chk("t2_lwi_wb_sel_wb", {63'd0, wb_sel}, 64'd1);
    repeat (2) tick();
    chk("t2_swi_fetch_pc", {54'd0, pc}, 64'd1);
    repeat (3) tick();
    chk("t2_swi_dm_req", {63'd0, dm_req}, 64'd1);
    chk("t2_swi_dm_we", {63'd0, dm_we}, 64'd1);
    chk("t2_swi_wb_sel", {63'd0, wb_sel}, 64'd0);
    repeat (4) tick();
    dm_ready = 1'b1;
    tick();
    chk("t2_swi_no_wb", {62'd0, reg_write_en, dm_req}, 64'd0);
    tick();
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_ins_cnt", ins_cnt, 64'd2);
    chk("t2_stall", stall_cnt, StallOn ? 64'd8 : 64'd0);
    // first fetch stalled for three cycles
    prog[0] = ADD; total_ir = 10'd1; im_ready = 1'b0;
    pulse_start();
    chk("t3_im_req0", {63'd0, im_req}, 64'd1);
    chk("t3_ir_not_latched", {58'd0, opcode}, 64'b001010);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("t3_im_req%0d", i), {63'd0, im_req}, 64'd1);
    end
    chk("t3_stall_opcode", {58'd0, opcode}, 64'b001010);
    im_ready = 1'b1;
    tick();
    chk("t3_im_req_drop", {63'd0, im_req}, 64'd0);
    chk("t3_latched", {43'd0, opcode, write_address, read_address1, read_address2}, {43'd0, 6'b100000, 5'd3, 5'd1, 5'd2});
    chk("t3_add_sel", {61'd0, imm_sel, alu_src2_sel}, 64'd0);
    chk("t3_pc_hold", {54'd0, pc}, 64'd0);
    run_to_done(4, 60, n);
    chk("t3_cycles", n, 64'd8);
    chk("t3_pc", {54'd0, pc}, 64'd1);
    chk("t3_stall", stall_cnt, StallOn ? 64'd3 : 64'd0);
    // illegal opcode then ADDI
    prog[0] = ILL; prog[1] = ADDI; total_ir = 10'd2;
    pulse_start();
    tick();
    chk("t4_dec_illegal_pre", {63'd0, illegal}, 64'd0);
    tick();
    chk("t4_illegal_set", {63'd0, illegal}, 64'd1);
    chk("t4_no_exec", {62'd0, alu_en, reg_write_en}, 64'd0);
    tick();
    chk("t4_next_pc", {54'd0, pc}, 64'd1);
    chk("t4_ins_cnt_mid", ins_cnt, 64'd1);
    run_to_done(3, 60, n);
    chk("t4_cycles", n, 64'd8);
    chk("t4_illegal_sticky", {63'd0, illegal}, 64'd1);
    chk("t4_ins_cnt", ins_cnt, 64'd2);
    // reset in the middle of a DM handshake
    prog[0] = LWI; total_ir = 10'd1; dm_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    chk("t5_mem_dm_req", {63'd0, dm_req}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_strobes", {57'd0, im_req, dm_req, dm_we, reg_read_en, alu_en, reg_write_en, done}, 64'd0);
    chk("t5_ir_cleared", {58'd0, opcode}, 64'd0);
    chk("t5_ins_cnt", ins_cnt, 64'd0);
    chk("t5_stall", stall_cnt, 64'd0);
    tick();
    chk("t5_idle_hold", {63'd0, im_req}, 64'd0);
    total_ir = 10'd0; dm_ready = 1'b1;
    pulse_start();
    chk("t5_zero_done", {63'd0, done}, 64'd1);
    chk("t5_zero_im_req", {63'd0, im_req}, 64'd0);
    chk("t5_zero_ins_cnt", ins_cnt, 64'd0);
    // maximum run length: 1023 NOPs end just before pc wraps
    foreach (prog[i]) prog[i] = NOP;
    total_ir = 10'd1023;
    pulse_start();
    chk("t6_nop_rd_sel", {62'd0, imm_sel}, 64'd0);
    run_to_done(0, 4000, n);
    chk("t6_cycles", n, 64'd3069);
    chk("t6_ins_cnt", ins_cnt, 64'd1023);
    chk("t6_pc", {54'd0, pc}, 64'd1023);
    tick();
    chk("t6_done_held", {63'd0, done}, 64'd1);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
